// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid and flush.
// Control payload is gated to zero whenever the stage presents a bubble.
module pipe_stage_skid #(
  parameter int DATA_W   = 256,
  parameter int CTRL_W   = 16,
  parameter bit SKID     = 1'b1,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t m_q, m_d, s_q, s_d, in_ent;
  logic m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic acc, pop;

  assign in_ent = '{ctrl: in_ctrl, data: in_data};

  // Skid mode takes in_ready straight from a flop; bypass mode looks through to out_ready.
  assign in_ready  = SKID ? !s_vld_q : (!m_vld_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = m_vld_q && out_ready;
  assign out_valid = m_vld_q;
  assign out_data  = m_q.data;
  assign out_ctrl  = m_vld_q ? m_q.ctrl : '0;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
      m_d.ctrl = '0;
      s_d.ctrl = '0;
      if (CLR_DATA) begin
        m_d.data = '0;
        s_d.data = '0;
      end
    end else if (SKID) begin
      if (m_vld_q && s_vld_q) begin
        // Full: in_ready is low, so only a pop can move things along.
        if (pop) begin
          m_d     = s_q;
          s_vld_d = 1'b0;
        end
      end else if (m_vld_q) begin
        if (acc && pop) begin
          m_d = in_ent;
        end else if (acc) begin
          s_d     = in_ent;
          s_vld_d = 1'b1;
        end else if (pop) begin
          m_vld_d = 1'b0;
        end
      end else if (acc) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end
    end else begin
      if (acc) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else if (pop) begin
        m_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q   <= 1'b0;
      s_vld_q   <= 1'b0;
      m_q.ctrl  <= '0;
      s_q.ctrl  <= '0;
      occupancy <= 2'd0;
      if (CLR_DATA) begin
        m_q.data <= '0;
        s_q.data <= '0;
      end
    end else begin
      m_vld_q   <= m_vld_d;
      s_vld_q   <= s_vld_d;
      m_q       <= m_d;
      s_q       <= s_d;
      occupancy <= {1'b0, m_vld_d} + {1'b0, s_vld_d};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + randomised bench for pipe_stage_skid: a skid/clear-data instance and a bypass instance
// share stimulus, each tracked by its own queue model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          rdy1, vld1, rdy0, vld0;
  logic [DW-1:0] dat1, dat0;
  logic [CW-1:0] ctl1, ctl0;
  logic [1:0]    occ1, occ0;

  int n_tot = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CLR_DATA(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .out_ctrl(ctl1),
    .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CLR_DATA(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .out_ctrl(ctl0),
    .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queues: {ctrl, data} per held entry
  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];

  always @(posedge clk) begin
    bit r1, r0, a1, a0, p1, p0;
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      r1 = (q1.size() < 2);
      r0 = (q0.size() == 0) || out_ready;
      a1 = in_valid && r1;
      a0 = in_valid && r0;
      p1 = (q1.size() > 0) && out_ready;
      p0 = (q0.size() > 0) && out_ready;
      if (p1) void'(q1.pop_front());
      if (p0) void'(q0.pop_front());
      if (a1) q1.push_back({in_ctrl, in_data});
      if (a0) q0.push_back({in_ctrl, in_data});
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m1_valid", vld1, q1.size() > 0);
      chk("m1_occ",   occ1, q1.size());
      chk("m1_ready", rdy1, q1.size() < 2);
      chk("m1_ctrl",  ctl1, (q1.size() > 0) ? q1[0][CW+DW-1:DW] : '0);
      if (q1.size() > 0) chk("m1_data", dat1, q1[0][DW-1:0]);
      chk("m0_valid", vld0, q0.size() > 0);
      chk("m0_occ",   occ0, q0.size());
      chk("m0_ready", rdy0, (q0.size() == 0) || out_ready);
      chk("m0_ctrl",  ctl0, (q0.size() > 0) ? q0[0][CW+DW-1:DW] : '0);
      if (q0.size() > 0) chk("m0_data", dat0, q0[0][DW-1:0]);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 32'h55; in_ctrl = 16'hFFFF;

    // reset held two cycles with in_valid high
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_valid1", vld1, 1'b0);
    chk("rst_ctrl1",  ctl1, 16'h0);
    chk("rst_occ1",   occ1, 2'd0);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_data1",  dat1, 32'h0);
    chk("rst_valid0", vld0, 1'b0);
    chk("rst_ready0", rdy0, 1'b1);
    mon_en = 1'b1;

    // back-to-back stream, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i; in_ctrl = 16'h0100 | 16'(i);
      tick();
      chk("str_valid1", vld1, 1'b1);
      chk("str_data1",  dat1, i);
      chk("str_ctrl1",  ctl1, 16'h0100 | 16'(i));
      chk("str_data0",  dat0, i);
      chk("str_occ1",   occ1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("str_drain1", vld1, 1'b0);
    chk("str_drain0", vld0, 1'b0);

    // stall fills the skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 16'h00A0;
    tick();
    chk("stl_occ_a",   occ1, 2'd1);
    chk("stl_ready_a", rdy1, 1'b1);
    in_data = 32'hB; in_ctrl = 16'h00B0;
    tick();
    in_valid = 1'b0;
    chk("stl_occ_b",   occ1, 2'd2);
    chk("stl_ready_b", rdy1, 1'b0);
    chk("stl_data_b",  dat1, 32'hA);
    chk("stl_ready0",  rdy0, 1'b0);
    chk("stl_data0",   dat0, 32'hA);
    tick();
    chk("stl_hold",    dat1, 32'hA);
    chk("stl_holdc",   ctl1, 16'h00A0);
    out_ready = 1'b1;
    #1;
    chk("byp_ready0",  rdy0, 1'b1);
    chk("skd_ready1",  rdy1, 1'b0);
    tick();
    chk("rel_data_b",  dat1, 32'hB);
    chk("rel_ready",   rdy1, 1'b1);
    chk("rel_occ",     occ1, 2'd1);
    tick();
    chk("rel_empty",   vld1, 1'b0);

    // flush with a full stage and a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 16'h1111; tick();
    in_data = 32'hA2; tick();
    chk("fl_occ2", occ1, 2'd2);
    flush = 1'b1; in_data = 32'hC; in_ctrl = 16'hFFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", vld1, 1'b0);
    chk("fl_ctrl",  ctl1, 16'h0);
    chk("fl_occ",   occ1, 2'd0);
    chk("fl_ready", rdy1, 1'b1);
    chk("fl_data",  dat1, 32'h0);
    chk("fl_valid0", vld0, 1'b0);
    // flush with one entry while in_ready is high: input still dropped
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 16'h2222; tick();
    flush = 1'b1; in_data = 32'hC; in_ctrl = 16'hFFFF; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl1_valid", vld1, 1'b0);
    chk("fl1_data",  dat1, 32'h0);
    tick();
    chk("fl1_never", vld1, 1'b0);

    // bubble gating
    in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_ctrl1", ctl1, 16'h0);
      chk("bub_ctrl0", ctl0, 16'h0);
    end

    // randomised traffic with periodic flush, checked by the monitor
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      flush     = ((c % 97) == 50);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("end_empty1", vld1, 1'b0);
    chk("end_empty0", vld0, 1'b0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
